// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Holds the state encoding, the search-mode codes and the select-width helper.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   localparam int CNT_W = 8;

   localparam logic MODE_FIRST = 1'b0;
   localparam logic MODE_NEXT  = 1'b1;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Channel search: the lowest enabled channel (first mode) or the lowest enabled
// channel strictly above the current one (next mode).
module mux_scan_next
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = 16,
   parameter int SEL_W = sel_width(N_CH)
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] ch,
   input  logic             mode,
   output logic [SEL_W-1:0] next_ch,
   output logic             found
);

   // Walk downwards so the last hit, which is the lowest qualifying bit, wins.
   always_comb begin
      next_ch = '0;
      found   = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i] && ((mode == MODE_FIRST) || (i > int'(ch)))) begin
            next_ch = SEL_W'(i);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer around a 16:1 mux: steps the select over the enabled channels, waits the
// settle time, samples the mux output and reports one capture word per sweep.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int N_CH       = 16,
   parameter int SEL_W      = sel_width(N_CH),
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             stop,
   input  logic [N_CH-1:0]  mask,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic [N_CH-1:0]  capture,
   output logic             done,
   output logic             busy
);

   scan_state_t      state;
   logic [N_CH-1:0]  mask_q;
   logic             cont_q;
   logic             stop_q;
   logic [N_CH-1:0]  shadow;
   logic [N_CH-1:0]  shadow_merged;
   logic [CNT_W-1:0] cnt;

   logic [SEL_W-1:0] start_ch;
   logic             start_found;
   logic [SEL_W-1:0] step_ch;
   logic             step_found;
   logic             step_mode;

   // Start looks at the live mask; advance and reload look at the latched one.
   mux_scan_next #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
      .mask    (mask),
      .ch      ('0),
      .mode    (MODE_FIRST),
      .next_ch (start_ch),
      .found   (start_found)
   );

   assign step_mode = (state == SCAN) ? MODE_NEXT : MODE_FIRST;

   mux_scan_next #(.N_CH(N_CH), .SEL_W(SEL_W)) u_step (
      .mask    (mask_q),
      .ch      (mux_sel),
      .mode    (step_mode),
      .next_ch (step_ch),
      .found   (step_found)
   );

   always_comb begin
      shadow_merged          = shadow;
      shadow_merged[mux_sel] = mux_out;
   end

   // stop may arrive anywhere in the sweep, so it is held until the DONE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         mux_sel <= '0;
         capture <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         shadow  <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mask_q <= mask;
                  cont_q <= cont;
                  stop_q <= 1'b0;
                  shadow <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (start_found) begin
                     mux_sel <= start_ch;
                     state   <= SCAN;
                  end else begin
                     capture <= '0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            SCAN: begin
               if (stop) begin
                  stop_q <= 1'b1;
               end
               if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  cnt    <= '0;
                  shadow <= shadow_merged;
                  if (step_found) begin
                     mux_sel <= step_ch;
                  end else begin
                     capture <= shadow_merged;
                     done    <= 1'b1;
                     state   <= DONE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (cont_q && !stop && !stop_q && step_found) begin
                  mux_sel <= step_ch;
                  cnt     <= '0;
                  shadow  <= '0;
                  state   <= SCAN;
               end else begin
                  stop_q <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driven by a 16:1 mux model with in=16'h3f0a.
// Captures are scoreboarded: pushed at start, popped on every done pulse.
module tb_mux_scan_ctrl;

   localparam int N_CH       = 16;
   localparam int SEL_W      = 4;
   localparam int SETTLE_CYC = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             cont;
   logic             stop;
   logic [N_CH-1:0]  mask;
   logic [SEL_W-1:0] mux_sel;
   logic             mux_out;
   logic [N_CH-1:0]  capture;
   logic             done;
   logic             busy;

   logic [N_CH-1:0]  mux_in = 16'h3f0a;

   int               errors = 0;
   int               checks = 0;
   logic [N_CH-1:0]  exp_q[$];

   typedef struct {
      logic [N_CH-1:0] mask;
      logic [N_CH-1:0] exp_cap;
   } vec_t;

   vec_t vecs[5];

   mux_scan_ctrl #(.N_CH(N_CH), .SEL_W(SEL_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cont    (cont),
      .stop    (stop),
      .mask    (mask),
      .mux_sel (mux_sel),
      .mux_out (mux_out),
      .capture (capture),
      .done    (done),
      .busy    (busy)
   );

   assign mux_out = mux_in[mux_sel];

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives start for exactly one edge and queues the capture that sweep must report.
   task automatic applyStimulus(input logic [N_CH-1:0] m, input logic c, input logic [N_CH-1:0] exp_cap);
      @(negedge clk);
      start = 1'b1;
      mask  = m;
      cont  = c;
      exp_q.push_back(exp_cap);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Walks a single sweep of latched mask m from just after the start edge to IDLE.
   task automatic checkSweep(input logic [N_CH-1:0] m, input bit disturb);
      int bits[$];
      for (int i = 0; i < N_CH; i++) begin
         if (m[i]) bits.push_back(i);
      end
      checkOutput("busy_at_start", {31'd0, busy}, 32'd1);
      for (int e = 0; e < bits.size() * SETTLE_CYC; e++) begin
         checkOutput("sweep_sel", {28'd0, mux_sel}, bits[e / SETTLE_CYC]);
         checkOutput("sweep_no_done", {31'd0, done}, 32'd0);
         if (disturb && e == 1) begin
            start = 1'b1;
            mask  = ~m;
            cont  = 1'b1;
         end
         if (disturb && e == 2) start = 1'b0;
         step();
      end
      checkOutput("sweep_done", {31'd0, done}, 32'd1);
      checkOutput("sweep_busy_done", {31'd0, busy}, 32'd1);
      step();
      checkOutput("sweep_done_clear", {31'd0, done}, 32'd0);
      checkOutput("sweep_idle_busy", {31'd0, busy}, 32'd0);
   endtask

   // Every done pulse must match the oldest outstanding expected capture.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, expected 0 at %0t", $time);
         end else begin
            checkOutput("capture", {16'd0, capture}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{mask: 16'hFFFF, exp_cap: 16'h3f0a};
      vecs[1] = '{mask: 16'h0105, exp_cap: 16'h0100};
      vecs[2] = '{mask: 16'h0000, exp_cap: 16'h0000};
      vecs[3] = '{mask: 16'h000A, exp_cap: 16'h000A};
      vecs[4] = '{mask: 16'hFF00, exp_cap: 16'h3F00};

      rst_n = 1'b0;
      start = 1'b0;
      cont  = 1'b0;
      stop  = 1'b0;
      mask  = '0;
      repeat (3) step();
      checkOutput("reset_sel", {28'd0, mux_sel}, 32'd0);
      checkOutput("reset_capture", {16'd0, capture}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].mask, 1'b0, vecs[i].exp_cap);
         checkSweep(vecs[i].mask, 1'b0);
         step();
      end

      $display("[TB] start and mask changes while busy");
      applyStimulus(16'h0105, 1'b0, 16'h0100);
      checkSweep(16'h0105, 1'b1);
      cont = 1'b0;
      step();

      $display("[TB] reset in the middle of a sweep");
      applyStimulus(16'hFFFF, 1'b0, 16'h3f0a);
      step();
      rst_n = 1'b0;
      step();
      checkOutput("midreset_sel", {28'd0, mux_sel}, 32'd0);
      checkOutput("midreset_capture", {16'd0, capture}, 32'd0);
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_done", {31'd0, done}, 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      step();
      checkOutput("postreset_busy", {31'd0, busy}, 32'd0);
      applyStimulus(16'hFFFF, 1'b0, 16'h3f0a);
      checkSweep(16'hFFFF, 1'b0);
      step();

      $display("[TB] continuous sweeps with stop");
      applyStimulus(16'h8001, 1'b1, 16'h0000);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      cont = 1'b0;
      for (int s = 0; s < 3; s++) begin
         for (int e = 0; e < 2 * SETTLE_CYC; e++) begin
            checkOutput("cont_sel", {28'd0, mux_sel}, (e < SETTLE_CYC) ? 32'd0 : 32'd15);
            checkOutput("cont_no_done", {31'd0, done}, 32'd0);
            if (s == 2 && e == 1) stop = 1'b1;
            if (s == 2 && e == 2) stop = 1'b0;
            step();
         end
         checkOutput("cont_done", {31'd0, done}, 32'd1);
         step();
         checkOutput("cont_busy", {31'd0, busy}, (s < 2) ? 32'd1 : 32'd0);
      end
      repeat (3) begin
         step();
         checkOutput("after_stop_done", {31'd0, done}, 32'd0);
         checkOutput("after_stop_busy", {31'd0, busy}, 32'd0);
      end

      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
